// File: rtl/kernel_kcore_start_fifo_param.sv
// Parametrised shift-register FIFO for kcore start/token channels with occupancy,
// almost-full/almost-empty flags, synchronous flush and sticky debug error flags.
module kernel_kcore_start_fifo_param #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1),
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic [CNT_WIDTH-1:0]  head;
    logic                  wr_req, rd_req, wr_acc, rd_acc;

    assign wr_req = if_write & if_write_ce;
    assign rd_req = if_read & if_read_ce;
    assign wr_acc = wr_req & if_full_n;
    assign rd_acc = rd_req & if_empty_n;

    // Oldest word sits at count-1; a simultaneous read+write shifts the next word into it.
    always_comb begin
        head = (count != '0) ? count - CNT_WIDTH'(1) : '0;
    end

    always_comb begin
        if_dout = mem[0];
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (head == CNT_WIDTH'(i)) if_dout = mem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[0] <= if_din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    always_comb begin
        cnt_nxt = count;
        if (flush) begin
            cnt_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            cnt_nxt = count + CNT_WIDTH'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_nxt = count - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            if_empty_n   <= 1'b0;
            if_full_n    <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= cnt_nxt;
            if_empty_n   <= (cnt_nxt != '0);
            if_full_n    <= (cnt_nxt != DEPTH_C);
            almost_full  <= (cnt_nxt >= AF_C);
            almost_empty <= (cnt_nxt <= AE_C);
        end
    end

    // Setting an error wins over a same-cycle clear; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && !if_full_n) overflow <= 1'b1;
            else if (err_clr)         overflow <= 1'b0;
            if (rd_req && !if_empty_n) underflow <= 1'b1;
            else if (err_clr)          underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kernel_kcore_start_fifo_param.sv
// Bench for kernel_kcore_start_fifo_param: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_kernel_kcore_start_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 3;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, flush, if_write, if_write_ce, if_read, if_read_ce, err_clr;
    logic [DW-1:0] if_din;
    logic [DW-1:0] if_dout;
    logic          if_full_n, if_empty_n, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    kernel_kcore_start_fifo_param #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .if_write    (if_write),
        .if_write_ce (if_write_ce),
        .if_din      (if_din),
        .if_full_n   (if_full_n),
        .if_read     (if_read),
        .if_read_ce  (if_read_ce),
        .if_dout     (if_dout),
        .if_empty_n  (if_empty_n),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .err_clr     (err_clr),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic drive(input logic w, input logic wce, input logic [DW-1:0] d,
                         input logic r, input logic rce, input logic fl,
                         input logic ec, input logic rs);
        if_write = w; if_write_ce = wce; if_din = d;
        if_read = r; if_read_ce = rce; flush = fl; err_clr = ec; reset = rs;
    endtask

    // One clock: model the edge from the FIFO's rules, then compare every output.
    task automatic tick();
        bit full, empty, wa, ra;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            wa = if_write && if_write_ce && !full;
            ra = if_read && if_read_ce && !empty;
            if (if_write && if_write_ce && full) m_ovf = 1'b1;
            else if (err_clr)                    m_ovf = 1'b0;
            if (if_read && if_read_ce && empty)  m_unf = 1'b1;
            else if (err_clr)                    m_unf = 1'b0;
            if (flush) q.delete();
            else begin
                if (ra) void'(q.pop_front());
                if (wa) q.push_back(if_din);
            end
        end
        #1;
        check("count",        32'(count),        32'(q.size()));
        check("if_empty_n",   32'(if_empty_n),   32'(q.size() != 0));
        check("if_full_n",    32'(if_full_n),    32'(q.size() != DEPTH));
        check("almost_full",  32'(almost_full),  32'(q.size() >= AF));
        check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_unf));
        if (q.size() != 0) check("if_dout", 32'(if_dout), 32'(q[0]));
    endtask

    initial begin
        logic [DW-1:0] v;
        int unsigned wp, rp;

        drive(0, 0, '0, 0, 0, 0, 0, 1);
        tick(); tick();
        drive(0, 0, '0, 0, 0, 0, 0, 0);
        tick();

        // Fill to full, then drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            v = DW'(8'h11 * i);
            drive(1, 1, v, 0, 0, 0, 0, 0);
            tick();
        end
        check("full_after_fill", 32'(if_full_n), 32'd0);
        check("count_after_fill", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, '0, 1, 1, 0, 0, 0);
            tick();
        end
        check("empty_after_drain", 32'(if_empty_n), 32'd0);

        // Steady simultaneous read+write at count 2.
        drive(1, 1, 8'h01, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 8'h02, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            v = DW'(i + 3);
            drive(1, 1, v, 1, 1, 0, 0, 0);
            tick();
        end
        check("count_hold_rw", 32'(count), 32'd2);

        // Full: read accepted, write dropped and flagged; then clear the flag.
        for (int i = 0; i < DEPTH - 2; i++) begin
            drive(1, 1, 8'hA0 + DW'(i), 0, 0, 0, 0, 0);
            tick();
        end
        drive(1, 1, 8'h99, 1, 1, 0, 0, 0); tick();
        check("ovf_full_rw", 32'(overflow), 32'd1);
        check("count_full_rw", 32'(count), 32'(DEPTH - 1));
        drive(0, 0, '0, 0, 0, 0, 1, 0); tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, '0, 1, 1, 0, 0, 0);
            tick();
        end

        // Empty: read with write flags underflow, write still lands.
        drive(1, 1, 8'h5A, 1, 1, 0, 0, 0); tick();
        check("unf_empty_rw", 32'(underflow), 32'd1);
        check("dout_5a", 32'(if_dout), 32'h5A);
        drive(1, 0, 8'h77, 0, 0, 0, 0, 0); tick();
        // Set beats clear.
        drive(0, 0, '0, 1, 1, 0, 1, 0); tick();
        drive(0, 0, '0, 1, 1, 0, 1, 0); tick();
        drive(0, 0, '0, 0, 0, 0, 0, 0); tick();

        // Flush at count 3 with a concurrent write, then reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 8'hC0 + DW'(i), 0, 0, 0, 0, 0);
            tick();
        end
        drive(1, 1, 8'hEE, 1, 1, 0, 0, 0); tick();
        drive(1, 1, 8'hEE, 0, 0, 1, 0, 0); tick();
        check("count_flush", 32'(count), 32'd0);
        check("ovf_kept_flush", 32'(overflow), 32'd0);
        drive(1, 1, 8'h31, 1, 1, 0, 0, 0); tick();
        drive(1, 1, 8'h32, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 8'h33, 1, 1, 0, 0, 1); tick();
        check("count_reset", 32'(count), 32'd0);
        check("unf_reset", 32'(underflow), 32'd0);

        // Random traffic with alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            wp = ((i / 100) % 2 == 0) ? 75 : 30;
            rp = 100 - wp;
            v = DW'($urandom);
            drive(($urandom % 100) < wp, ($urandom % 8) != 0, v,
                  ($urandom % 100) < rp, ($urandom % 8) != 0,
                  ($urandom % 60) == 0, ($urandom % 25) == 0,
                  ($urandom % 400) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
